// File: rtl/traffic_pkg.sv
// Shared constants for the traffic queue estimator and its controller.
// Direction indices, default thresholds and default widths.
package traffic_pkg;

    localparam int NUM_DIR = 4;

    localparam int DIR_NS = 0;
    localparam int DIR_SN = 1;
    localparam int DIR_EW = 2;
    localparam int DIR_WE = 3;

    localparam int DEF_CNT_W      = 4;
    localparam int DEF_DEB_CYCLES = 2;
    localparam int DEF_S1_TH      = 1;
    localparam int DEF_S5_TH      = 5;

endpackage

// File: rtl/traffic_queue_estimator_if.sv
// One direction's detector inputs and conditioned outputs.
// master: detector side (drives det_*); slave: lane counter (drives results).
interface traffic_queue_estimator_if #(
    parameter int CNT_W = 4
);

    logic             det_in;
    logic             det_out;
    logic             s1;
    logic             s5;
    logic             err;
    logic [CNT_W-1:0] count;

    modport master (
        output det_in, det_out,
        input  s1, s5, err, count
    );

    modport slave (
        input  det_in, det_out,
        output s1, s5, err, count
    );

endinterface

// File: rtl/lane_queue_counter.sv
// One direction: sync + debounce + rise detect on approach and stop-line
// detectors, saturating queue counter, threshold flags and sticky err.
// Ports: clk, rst (sync, active-high), lane (slave modport).
module lane_queue_counter
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int S1_TH      = DEF_S1_TH,
    parameter int S5_TH      = DEF_S5_TH
) (
    input logic clk,
    input logic rst,
    traffic_queue_estimator_if.slave lane
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam logic [CNT_W-1:0] MAX = '1;
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    // bit 0: approach chain, bit 1: stop-line chain
    logic [1:0]         raw;
    logic [1:0]         sync1;
    logic [1:0]         sync2;
    logic [1:0]         level;
    logic [1:0]         level_q;
    logic [1:0][DW-1:0] deb_cnt;

    logic [CNT_W-1:0] count;
    logic             s1_q;
    logic             s5_q;
    logic             err_q;
    logic             inc;
    logic             dec;

    assign raw = {lane.det_out, lane.det_in};
    assign inc = level[0] & ~level_q[0];
    assign dec = level[1] & ~level_q[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1   <= '0;
            sync2   <= '0;
            level   <= '0;
            level_q <= '0;
            deb_cnt <= '0;
            count   <= '0;
            s1_q    <= 1'b0;
            s5_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1   <= raw;
            sync2   <= sync1;
            level_q <= level;

            for (int k = 0; k < 2; k++) begin
                if (sync2[k] == level[k]) begin
                    deb_cnt[k] <= '0;
                end else if (deb_cnt[k] == DEB_LAST) begin
                    level[k]   <= ~level[k];
                    deb_cnt[k] <= '0;
                end else begin
                    deb_cnt[k] <= deb_cnt[k] + 1'b1;
                end
            end

            // simultaneous inc and dec cancel, even at the rails
            unique case ({inc, dec})
                2'b10: begin
                    if (count == MAX) err_q <= 1'b1;
                    else              count <= count + 1'b1;
                end
                2'b01: begin
                    if (count == '0) err_q <= 1'b1;
                    else             count <= count - 1'b1;
                end
                default: ;
            endcase

            // compares the already-updated count, hence one cycle behind it
            s1_q <= (count >= CNT_W'(S1_TH));
            s5_q <= (count >= CNT_W'(S5_TH));
        end
    end

    assign lane.count = count;
    assign lane.s1    = s1_q;
    assign lane.s5    = s5_q;
    assign lane.err   = err_q;

endmodule

// File: rtl/traffic_queue_estimator.sv
// Queue occupancy estimator for four approach directions (NS, SN, EW, WE).
// Ports: clk, rst, det_in_*/det_out_* raw detectors, S1_*/S5_* flags,
// q_count packed counts (NS lowest), err sticky per-direction errors.
module traffic_queue_estimator
    import traffic_pkg::*;
#(
    parameter int CNT_W      = DEF_CNT_W,
    parameter int DEB_CYCLES = DEF_DEB_CYCLES,
    parameter int S1_TH      = DEF_S1_TH,
    parameter int S5_TH      = DEF_S5_TH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 det_in_NS,
    input  logic                 det_in_SN,
    input  logic                 det_in_EW,
    input  logic                 det_in_WE,
    input  logic                 det_out_NS,
    input  logic                 det_out_SN,
    input  logic                 det_out_EW,
    input  logic                 det_out_WE,
    output logic                 S1_NS,
    output logic                 S1_SN,
    output logic                 S1_EW,
    output logic                 S1_WE,
    output logic                 S5_NS,
    output logic                 S5_SN,
    output logic                 S5_EW,
    output logic                 S5_WE,
    output logic [4*CNT_W-1:0]   q_count,
    output logic [3:0]           err
);

    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] s1;
    logic [3:0] s5;

    assign din  = {det_in_WE, det_in_EW, det_in_SN, det_in_NS};
    assign dout = {det_out_WE, det_out_EW, det_out_SN, det_out_NS};

    for (genvar g = 0; g < NUM_DIR; g++) begin : g_lane
        traffic_queue_estimator_if #(.CNT_W(CNT_W)) lane ();

        assign lane.det_in  = din[g];
        assign lane.det_out = dout[g];

        lane_queue_counter #(
            .CNT_W      (CNT_W),
            .DEB_CYCLES (DEB_CYCLES),
            .S1_TH      (S1_TH),
            .S5_TH      (S5_TH)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .lane (lane)
        );

        assign s1[g]                   = lane.s1;
        assign s5[g]                   = lane.s5;
        assign err[g]                  = lane.err;
        assign q_count[g*CNT_W +: CNT_W] = lane.count;
    end

    assign S1_NS = s1[DIR_NS];
    assign S1_SN = s1[DIR_SN];
    assign S1_EW = s1[DIR_EW];
    assign S1_WE = s1[DIR_WE];
    assign S5_NS = s5[DIR_NS];
    assign S5_SN = s5[DIR_SN];
    assign S5_EW = s5[DIR_EW];
    assign S5_WE = s5[DIR_WE];

endmodule

// File: tb/tb_traffic_queue_estimator.sv
// Self-checking bench for traffic_queue_estimator with a history-window model.
// Directed detector pulses; per-cycle compare plus literal timing checks.
module tb_traffic_queue_estimator;

    localparam int CNT_W = 4;
    localparam int DEB   = 2;
    localparam int S1TH  = 1;
    localparam int S5TH  = 5;
    localparam int MAXC  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst;
    logic [3:0] din;
    logic [3:0] dout;
    logic [3:0] s1w;
    logic [3:0] s5w;
    logic [4*CNT_W-1:0] q_count;
    logic [3:0] err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    traffic_queue_estimator_if #(.CNT_W(CNT_W)) tb_lane [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_mon
        assign tb_lane[g].det_in  = din[g];
        assign tb_lane[g].det_out = dout[g];
        assign tb_lane[g].s1      = s1w[g];
        assign tb_lane[g].s5      = s5w[g];
        assign tb_lane[g].err     = err[g];
        assign tb_lane[g].count   = q_count[g*CNT_W +: CNT_W];
    end

    traffic_queue_estimator #(
        .CNT_W(CNT_W), .DEB_CYCLES(DEB), .S1_TH(S1TH), .S5_TH(S5TH)
    ) dut (
        .clk(clk), .rst(rst),
        .det_in_NS(din[0]), .det_in_SN(din[1]),
        .det_in_EW(din[2]), .det_in_WE(din[3]),
        .det_out_NS(dout[0]), .det_out_SN(dout[1]),
        .det_out_EW(dout[2]), .det_out_WE(dout[3]),
        .S1_NS(s1w[0]), .S1_SN(s1w[1]), .S1_EW(s1w[2]), .S1_WE(s1w[3]),
        .S5_NS(s5w[0]), .S5_SN(s5w[1]), .S5_EW(s5w[2]), .S5_WE(s5w[3]),
        .q_count(q_count), .err(err)
    );

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: raw samples per edge kept in a short history. A detector's clean
    // level flips once the DEB most recent samples that have crossed the
    // two-stage synchroniser all disagree with it. A rising clean level is a
    // vehicle event that moves the count on the following edge; flags report
    // the count as it stood one edge earlier.
    bit [7:0] hist [8];
    bit [7:0] lvl;
    bit [7:0] pend;
    int       cnt_m [4];
    bit [3:0] err_m;
    bit [3:0] s1_m;
    bit [3:0] s5_m;
    bit       mvalid = 1'b0;

    always @(posedge clk) begin : model
        bit [7:0] h [8];
        bit [7:0] l;
        bit [7:0] p;
        int       c [4];
        bit [3:0] e, f1, f5;
        bit       smp, alldiff, up, dn;
        h = hist; l = lvl; p = pend; c = cnt_m;
        e = err_m; f1 = s1_m; f5 = s5_m;
        if (rst) begin
            for (int i = 0; i < 8; i++) h[i] = '0;
            l = '0; p = '0; e = '0; f1 = '0; f5 = '0;
            for (int d = 0; d < 4; d++) c[d] = 0;
        end else begin
            for (int d = 0; d < 4; d++) begin
                f1[d] = (c[d] >= S1TH);
                f5[d] = (c[d] >= S5TH);
                up = p[d];
                dn = p[d+4];
                if (up && !dn) begin
                    if (c[d] == MAXC) e[d] = 1'b1;
                    else c[d] = c[d] + 1;
                end else if (dn && !up) begin
                    if (c[d] == 0) e[d] = 1'b1;
                    else c[d] = c[d] - 1;
                end
            end
            for (int i = 0; i < 8; i++) begin
                smp = (i < 4) ? din[i] : dout[i-4];
                h[i] = {h[i][6:0], smp};
                alldiff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (h[i][2+j] == l[i]) alldiff = 1'b0;
                p[i] = alldiff && !l[i];
                if (alldiff) l[i] = ~l[i];
            end
        end
        hist <= h; lvl <= l; pend <= p; cnt_m <= c;
        err_m <= e; s1_m <= f1; s5_m <= f5;
        if (rst) mvalid <= 1'b1;
    end

    always @(negedge clk) begin
        if (mvalid) begin
            for (int d = 0; d < 4; d++)
                chk($sformatf("cyc_q%0d", d), int'(q_count[d*CNT_W +: CNT_W]), cnt_m[d]);
            chk("cyc_s1", int'(s1w), int'(s1_m));
            chk("cyc_s5", int'(s5w), int'(s5_m));
            chk("cyc_err", int'(err), int'(err_m));
        end
    end

    function automatic int qd(input int d);
        return int'(q_count[d*CNT_W +: CNT_W]);
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int d, input bit stop);
        if (stop) dout[d] = 1'b1;
        else      din[d]  = 1'b1;
        step(4);
        if (stop) dout[d] = 1'b0;
        else      din[d]  = 1'b0;
        step(4);
    endtask

    initial begin
        rst = 1'b1; din = '0; dout = '0;
        step(3);
        chk("rst_q", int'(q_count), 0);
        chk("rst_s1", int'(s1w), 0);
        chk("rst_s5", int'(s5w), 0);
        chk("rst_err", int'(err), 0);
        rst = 1'b0;
        step(6);
        chk("idle_q", int'(q_count), 0);
        chk("idle_s1", int'(s1w), 0);

        // NS: 4-cycle approach pulse, count at E5, S1 at E6
        din[0] = 1'b1;
        step(4);
        chk("ns_e4_q", qd(0), 0);
        din[0] = 1'b0;
        step(1);
        chk("ns_e5_q", qd(0), 1);
        chk("ns_e5_model", cnt_m[0], 1);
        chk("ns_e5_s1", int'(s1w[0]), 0);
        step(1);
        chk("ns_e6_s1", int'(s1w[0]), 1);
        chk("ns_e6_model_s1", int'(s1_m[0]), 1);
        chk("ns_e6_s5", int'(s5w[0]), 0);
        step(4);
        // single-cycle glitch is rejected
        din[0] = 1'b1;
        step(1);
        din[0] = 1'b0;
        step(8);
        chk("ns_glitch_q", qd(0), 1);

        // SN: five vehicles then one departure
        repeat (4) pulse(1, 1'b0);
        chk("sn4_s5", int'(s5w[1]), 0);
        pulse(1, 1'b0);
        chk("sn5_q", qd(1), 5);
        chk("sn5_s5", int'(s5w[1]), 1);
        pulse(1, 1'b1);
        chk("sn_dep_q", qd(1), 4);
        chk("sn_dep_s5", int'(s5w[1]), 0);
        chk("sn_dep_s1", int'(s1w[1]), 1);

        // EW: simultaneous inc/dec at zero, then underflow
        din[2] = 1'b1; dout[2] = 1'b1;
        step(4);
        din[2] = 1'b0; dout[2] = 1'b0;
        step(4);
        chk("ew_both_q", qd(2), 0);
        chk("ew_both_err", int'(err[2]), 0);
        pulse(2, 1'b1);
        chk("ew_under_q", qd(2), 0);
        chk("ew_under_err", int'(err[2]), 1);
        chk("ew_under_model", int'(err_m[2]), 1);

        // WE: saturate at 15, sixteenth vehicle overflows
        repeat (15) pulse(3, 1'b0);
        chk("we15_q", qd(3), 15);
        chk("we15_err", int'(err[3]), 0);
        pulse(3, 1'b0);
        chk("we16_q", qd(3), 15);
        chk("we16_err", int'(err[3]), 1);

        // reset mid-operation with NS approach held high
        din[0] = 1'b1;
        step(2);
        rst = 1'b1;
        step(1);
        chk("mid_rst_q", int'(q_count), 0);
        chk("mid_rst_err", int'(err), 0);
        chk("mid_rst_s1", int'(s1w), 0);
        chk("mid_rst_s5", int'(s5w), 0);
        rst = 1'b0;
        step(8);
        din[0] = 1'b0;
        step(6);
        chk("post_rst_ns_q", qd(0), 1);
        chk("post_rst_ns_s1", int'(s1w[0]), 1);
        chk("post_rst_sn_q", qd(1), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/traffic_queue_estimator.md
# traffic_queue_estimator

Upstream conditioning stage for `adaptive_traffic_light_controller`. Per direction (NS, SN, EW, WE) it takes two raw loop-detector inputs:
- an approach detector, upstream of the stop line;
- a stop-line detector.

Each input is synchronised and debounced, and each clean vehicle passage is turned into an event. A saturating queue-occupancy counter is kept per direction. The block drives the controller's `S1_*` (queue ≥ 1 vehicle) and `S5_*` (queue ≥ 5 vehicles) inputs directly from registered threshold compares.

## Interface
Parameters
- `CNT_W`, 4 — queue counter width; max count = 2^CNT_W−1.
- `DEB_CYCLES`, 2 — consecutive identical samples required to accept a detector level change (≥1).
- `S1_TH`, 1 — occupancy threshold for `S1_*`.
- `S5_TH`, 5 — occupancy threshold for `S5_*`; must satisfy S1_TH ≤ S5_TH ≤ 2^CNT_W−1.

Ports
- `clk` in 1 — single clock; every register is in this domain.
- `rst` in 1 — reset is synchronous and active-high.
- `det_in_NS`, `det_in_SN`, `det_in_EW`, `det_in_WE` in 1 each — raw approach detector, asynchronous level (high while vehicle over loop).
- `det_out_NS`, `det_out_SN`, `det_out_EW`, `det_out_WE` in 1 each — raw stop-line detector, asynchronous level.
- `S1_NS`, `S1_SN`, `S1_EW`, `S1_WE` out 1 each — queue ≥ S1_TH.
- `S5_NS`, `S5_SN`, `S5_EW`, `S5_WE` out 1 each — queue ≥ S5_TH.
- `q_count` out 4×CNT_W — packed occupancy counts, NS in [CNT_W−1:0], then SN, EW, WE.
- `err` out 4 — sticky per-direction flag (bit order NS, SN, EW, WE). Set on overflow attempt or underflow attempt.

## Operation
- Reset behaviour: while `rst` is high at a clock edge, all of the following clear to 0: synchronisers, debounce counters, debounced levels, edge-detect registers, `q_count`, `err`, and all `S1_*`/`S5_*`.
  - A detector held high across reset is seen as a new rising level afterwards and counts once.
- Synchroniser: each raw input goes through a 2-flop synchroniser.
- Debounce, one per input:
  - Holds a debounced level and a sample counter.
  - While the synchronised sample differs from the debounced level, the counter increments; any match clears the counter.
  - When the DEB_CYCLES-th consecutive differing sample is seen, the debounced level flips and the counter clears.
  - Pulses shorter than DEB_CYCLES samples are ignored.
- Event generation: a rising edge of a debounced level produces a 1-cycle event. Approach produces `inc`; stop-line produces `dec`.
- Counter update per direction:
  - `inc` only: +1, unless at max. At max, hold and set `err`.
  - `dec` only: −1, unless 0. At 0, hold and set `err`.
  - `inc` and `dec` in the same cycle: count unchanged, no error, even at 0 or max.
- Flags: `S1_x` and `S5_x` are registered compares of the updated count, so they lag `q_count` by one cycle. Flags are monotonic with the count; no hysteresis.
- `err` bits are cleared only by `rst`.

## Timing
- Edge E1 is the first edge at which a raw input is sampled high.
  - Debounced level flips at E(2+DEB_CYCLES).
  - `q_count` updates at E(3+DEB_CYCLES).
  - `S1`/`S5` update at E(4+DEB_CYCLES); that is E6 with the default DEB_CYCLES = 2.
- Falling levels follow the same debounce latency but generate no event.
- Minimum separation between accepted events on one input is 2·DEB_CYCLES cycles (high then low must each debounce).
- The four directions are fully independent; no arbitration.

## Structure
- Shared package `traffic_pkg`:
  - direction index constants DIR_NS = 0, DIR_SN = 1, DIR_EW = 2, DIR_WE = 3;
  - default thresholds S1_TH / S5_TH, shared with the controller.
- Sub-module `lane_queue_counter`: one direction, i.e. two sync+debounce+edge chains plus the counter, the flag registers and the err bit. Instantiated four times. Debounce logic may be a local function or repeated inline.

## Test plan
- Reset, then idle with all detectors low → every output stays 0; `q_count` = 0.
- `det_in_NS` high for 4 cycles (DEB = 2) → `q_count` NS = 1 at E5, `S1_NS` = 1 at E6, `S5_NS` = 0. `det_in_NS` high for 1 cycle → no change.
- Five clean approach pulses on SN → `S5_SN` rises one cycle after count reaches 5. One stop-line pulse → count 4, `S5_SN` falls, `S1_SN` stays 1.
- Approach and stop-line events on EW in the same cycle at count 0 → count stays 0, `err[2]` = 0. Stop-line pulse alone at 0 → count 0, `err[2]` = 1.
- Sixteen approach pulses on WE (CNT_W = 4) → count saturates at 15, `err[3]` = 1.
- Assert `rst` mid-operation with counts nonzero and `det_in_NS` held high → all outputs 0 after the reset edge; after release, NS counts exactly one vehicle.
